// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 16-bit instructions, issues register operands to the 8-bit ALU,
// waits out the ALU latency and writes result/psr back. Optional macro: ALU_ISSUE_IMM_EN.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 2,
    parameter int NREGS   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_rdataA,
    output logic [7:0]  alu_rdataB,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_psr,
    output logic        done,
    output logic [4:0]  flags,
    input  logic [3:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam int         CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [3:0] FUNC_CMP = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [7:0]    opa_q, opa_d;
    logic [7:0]    opb_q, opb_d;
    logic [3:0]    rd_q, rd_d;
    logic          wb_q, wb_d;
    logic          issued_q, issued_d;
    logic [4:0]    flags_q, flags_d;
    logic [7:0]    regs_q [NREGS];
    logic          rf_we;

    logic [3:0]    in_class, in_func, in_rd, in_rs;
    logic          in_supported;
    logic [7:0]    in_opa, in_opb;
    logic [7:0]    unused_result_hi;

    assign in_class = instr[15:12];
    assign in_func  = instr[11:8];
    assign in_rd    = instr[7:4];
    assign in_rs    = instr[3:0];

    // Upper result byte has no destination; carry-out is not retained.
    assign unused_result_hi = alu_result[15:8];

    // Class decode; r0 is never written, but force its read to zero regardless.
    always_comb begin
        in_supported = (in_class == 4'h0);
        in_opa       = (in_rd == 4'h0) ? '0 : regs_q[in_rd];
        in_opb       = (in_rs == 4'h0) ? '0 : regs_q[in_rs];
`ifdef ALU_ISSUE_IMM_EN
        if (in_class == 4'h1) begin
            in_supported = 1'b1;
            in_opb       = {4'b0000, in_rs};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opcode_d = opcode_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        rd_d     = rd_q;
        wb_d     = wb_q;
        issued_d = issued_q;
        flags_d  = flags_q;
        rf_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    rd_d = in_rd;
                    if (in_supported) begin
                        opcode_d = {4'h0, in_func};
                        opa_d    = in_opa;
                        opb_d    = in_opb;
                        wb_d     = (in_func != FUNC_CMP) && (in_rd != 4'h0);
                        issued_d = 1'b1;
                        state_d  = S_ISSUE;
                    end else begin
                        wb_d     = 1'b0;
                        issued_d = 1'b0;
                        state_d  = S_CAPTURE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(ALU_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CAPTURE: begin
                if (issued_q) begin
                    flags_d = alu_psr;
                end
                rf_we    = wb_q;
                opcode_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opcode_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            issued_q <= 1'b0;
            flags_q  <= '0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
            issued_q <= issued_d;
            flags_q  <= flags_d;
            if (rf_we) begin
                regs_q[rd_q] <= alu_result[7:0];
            end
        end
    end

    // Gated by reset so an abort in CAPTURE never shows a retire or a ready.
    assign instr_ready = (state_q == S_IDLE) && reset;
    assign done        = (state_q == S_CAPTURE) && reset;
    assign alu_opcode  = opcode_q;
    assign alu_rdataA  = opa_q;
    assign alu_rdataB  = opb_q;
    assign flags       = flags_q;
    assign dbg_data    = (dbg_addr == 4'h0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a two-stage behavioural ALU stub (ALU_LAT=2).
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [7:0]  alu_opcode, alu_rdataA, alu_rdataB;
    logic [15:0] alu_result;
    logic [4:0]  alu_psr;
    logic        done;
    logic [4:0]  flags;
    logic [3:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    alu_issue_ctrl #(.ALU_LAT(2), .NREGS(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_opcode (alu_opcode),
        .alu_rdataA (alu_rdataA),
        .alu_rdataB (alu_rdataB),
        .alu_result (alu_result),
        .alu_psr    (alu_psr),
        .done       (done),
        .flags      (flags),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // ALU stub: psr = {N, Z, F, L, C}; funcs 5/6 add, 9 sub, B compare, others 0.
    logic        inject_en = 1'b0;
    logic [7:0]  inject_val = '0;
    logic [15:0] res_c, s1_res, s2_res;
    logic [4:0]  psr_c, s1_psr, s2_psr;
    logic [8:0]  sum9, diff9;

    always_comb begin
        sum9  = {1'b0, alu_rdataA} + {1'b0, alu_rdataB};
        diff9 = {1'b0, alu_rdataA} - {1'b0, alu_rdataB};
        res_c = '0;
        psr_c = '0;
        case (alu_opcode[3:0])
            4'h5, 4'h6: begin
                res_c = {7'b0, sum9};
                psr_c = {sum9[7], sum9[7:0] == 8'h00,
                         (alu_rdataA[7] == alu_rdataB[7]) && (sum9[7] != alu_rdataA[7]),
                         1'b0, sum9[8]};
            end
            4'h9: begin
                res_c = {8'h00, diff9[7:0]};
                psr_c = {diff9[7], diff9[7:0] == 8'h00,
                         (alu_rdataA[7] != alu_rdataB[7]) && (diff9[7] != alu_rdataA[7]),
                         alu_rdataA < alu_rdataB, 1'b0};
            end
            4'hB: begin
                res_c = {8'h00, diff9[7:0]};
                psr_c = {$signed(alu_rdataA) < $signed(alu_rdataB), alu_rdataA == alu_rdataB,
                         1'b0, alu_rdataA < alu_rdataB, 1'b0};
            end
            default: begin
                res_c = '0;
                psr_c = '0;
            end
        endcase
        if (inject_en) begin
            res_c = {8'h00, inject_val};
            psr_c = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_res <= '0; s1_psr <= '0; s2_res <= '0; s2_psr <= '0;
        end else begin
            s1_res <= res_c; s1_psr <= psr_c; s2_res <= s1_res; s2_psr <= s1_psr;
        end
    end

    assign alu_result = s2_res;
    assign alu_psr    = s2_psr;

    task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    // Returns one cycle after the done cycle; lat counts negedges from accept to done seen.
    task automatic run_instr(input logic [15:0] ins, output int lat,
                             output logic rdy_done, output logic rdy_next,
                             output logic [7:0] op_s, output logic [7:0] a_s, output logic [7:0] b_s);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        op_s = alu_opcode;
        a_s = alu_rdataA;
        b_s = alu_rdataB;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        rdy_done = instr_ready;
        @(negedge clock);
        rdy_next = instr_ready;
    endtask

    task automatic preload(input logic [3:0] r, input logic [7:0] v);
        int lat;
        logic a, b;
        logic [7:0] o, x, y;
        inject_val = v;
        inject_en = 1'b1;
        run_instr({4'h0, 4'h6, r, 4'h0}, lat, a, b, o, x, y);
        inject_en = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (flags !== 5'h00) begin errors++; $display("FAIL reset_flags: got %h want 00", flags); end
        checks++; if (alu_opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode: got %h want 00", alu_opcode); end
        checks++; if ({alu_rdataA, alu_rdataB} !== 16'h0000) begin errors++; $display("FAIL reset_operands: got %h want 0000", {alu_rdataA, alu_rdataB}); end
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h want 00", i, v); end
        end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", instr_ready); end
    endtask

    task automatic test_addu;
        int lat; logic rd_, rn; logic [7:0] o, a, b, v;
        preload(4'd1, 8'h3C);
        preload(4'd2, 8'h0F);
        run_instr(16'h0612, lat, rd_, rn, o, a, b);
        checks++; if (lat !== 4) begin errors++; $display("FAIL addu_latency: got %0d want 4", lat); end
        checks++; if ({o, a, b} !== 24'h063C0F) begin errors++; $display("FAIL addu_issue: got %h want 063c0f", {o, a, b}); end
        checks++; if (rd_ !== 1'b0) begin errors++; $display("FAIL addu_ready_in_done: got %b want 0", rd_); end
        checks++; if (rn !== 1'b1) begin errors++; $display("FAIL addu_ready_after_done: got %b want 1", rn); end
        checks++; if (alu_opcode !== 8'h00) begin errors++; $display("FAIL addu_opcode_cleared: got %h want 00", alu_opcode); end
        read_reg(4'd1, v);
        checks++; if (v !== 8'h4B) begin errors++; $display("FAIL addu_r1: got %h want 4b", v); end
        read_reg(4'd2, v);
        checks++; if (v !== 8'h0F) begin errors++; $display("FAIL addu_r2: got %h want 0f", v); end
    endtask

    task automatic test_cmp;
        int lat; logic rd_, rn; logic [7:0] o, a, b, v;
        preload(4'd1, 8'h05);
        preload(4'd2, 8'h05);
        run_instr(16'h0B12, lat, rd_, rn, o, a, b);
        checks++; if (lat !== 4) begin errors++; $display("FAIL cmp_latency: got %0d want 4", lat); end
        checks++; if (o !== 8'h0B) begin errors++; $display("FAIL cmp_opcode: got %h want 0b", o); end
        read_reg(4'd1, v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL cmp_r1_kept: got %h want 05", v); end
        checks++; if (flags[3] !== 1'b1 || flags[1] !== 1'b0) begin errors++; $display("FAIL cmp_flag_bits: got %b want Z=1 L=0", flags); end
        checks++; if (flags !== 5'h08) begin errors++; $display("FAIL cmp_flags: got %h want 08", flags); end
    endtask

    task automatic test_rd0;
        int lat; logic rd_, rn; logic [7:0] o, a, b, v;
        preload(4'd1, 8'h05);
        preload(4'd2, 8'h05);
        run_instr(16'h0B12, lat, rd_, rn, o, a, b);
        run_instr(16'h0502, lat, rd_, rn, o, a, b);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd0_done_latency: got %0d want 4", lat); end
        checks++; if ({a, b} !== 16'h0005) begin errors++; $display("FAIL rd0_operands: got %h want 0005", {a, b}); end
        read_reg(4'd0, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rd0_r0: got %h want 00", v); end
        checks++; if (flags !== 5'h00) begin errors++; $display("FAIL rd0_flags_updated: got %h want 00", flags); end
    endtask

    task automatic test_same_reg;
        int lat; logic rd_, rn; logic [7:0] o, a, b, v;
        preload(4'd5, 8'h81);
        run_instr(16'h0655, lat, rd_, rn, o, a, b);
        checks++; if ({a, b} !== 16'h8181) begin errors++; $display("FAIL samereg_operands: got %h want 8181", {a, b}); end
        read_reg(4'd5, v);
        checks++; if (v !== 8'h02) begin errors++; $display("FAIL samereg_r5: got %h want 02", v); end
        checks++; if (flags !== 5'h05) begin errors++; $display("FAIL samereg_flags: got %h want 05", flags); end
    endtask

    task automatic test_unlisted;
        int lat; logic rd_, rn; logic [7:0] o, a, b, v;
        preload(4'd1, 8'hAA);
        run_instr(16'h0E12, lat, rd_, rn, o, a, b);
        checks++; if (o !== 8'h0E) begin errors++; $display("FAIL unlisted_opcode: got %h want 0e", o); end
        read_reg(4'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL unlisted_r1: got %h want 00", v); end
    endtask

    task automatic test_nop;
        int lat; logic rd_, rn; logic [7:0] o, a, b, v;
        preload(4'd1, 8'h07);
        preload(4'd2, 8'h07);
        run_instr(16'h0B12, lat, rd_, rn, o, a, b);
        run_instr(16'h2612, lat, rd_, rn, o, a, b);
        checks++; if (lat !== 1) begin errors++; $display("FAIL nop_latency: got %0d want 1", lat); end
        checks++; if (o !== 8'h00) begin errors++; $display("FAIL nop_opcode: got %h want 00", o); end
        checks++; if (rn !== 1'b1) begin errors++; $display("FAIL nop_ready_after: got %b want 1", rn); end
        checks++; if (flags !== 5'h08) begin errors++; $display("FAIL nop_flags_kept: got %h want 08", flags); end
        read_reg(4'd1, v);
        checks++; if (v !== 8'h07) begin errors++; $display("FAIL nop_r1: got %h want 07", v); end
    endtask

    task automatic test_imm;
        int lat, exp_lat; logic rd_, rn; logic [7:0] o, a, b, v, exp_r3;
`ifdef ALU_ISSUE_IMM_EN
        exp_lat = 4; exp_r3 = 8'h17;
`else
        exp_lat = 1; exp_r3 = 8'h10;
`endif
        preload(4'd3, 8'h10);
        run_instr(16'h1537, lat, rd_, rn, o, a, b);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL imm_latency: got %0d want %0d", lat, exp_lat); end
        read_reg(4'd3, v);
        checks++; if (v !== exp_r3) begin errors++; $display("FAIL imm_r3: got %h want %h", v, exp_r3); end
    endtask

    task automatic test_back_to_back;
        int first, second, n; logic [7:0] v;
        preload(4'd6, 8'h01);
        preload(4'd7, 8'h02);
        first = -1; second = -1;
        instr = 16'h0667;
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && second < 0; i++) begin
            if (instr_ready === 1'b1) begin
                if (first < 0) first = i; else second = i;
            end
            @(negedge clock);
        end
        instr_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        checks++; if (second - first !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", second - first); end
        read_reg(4'd6, v);
        checks++; if (v !== 8'h05) begin errors++; $display("FAIL b2b_r6: got %h want 05", v); end
    endtask

    task automatic test_reset_abort;
        int pulses; logic [7:0] v;
        preload(4'd1, 8'h20);
        preload(4'd2, 8'h01);
        pulses = 0;
        instr = 16'h0912;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) begin @(negedge clock); if (done === 1'b1) pulses++; end
        reset = 1'b1;
        repeat (6) begin @(negedge clock); if (done === 1'b1) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_done_pulses: got %0d want 0", pulses); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b want 1", instr_ready); end
        read_reg(4'd1, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_r1: got %h want 00", v); end
        checks++; if (flags !== 5'h00) begin errors++; $display("FAIL abort_flags: got %h want 00", flags); end
    endtask

    initial begin
        test_reset;
        test_addu;
        test_cmp;
        test_rd0;
        test_same_reg;
        test_unlisted;
        test_nop;
        test_imm;
        test_back_to_back;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
